// File: rtl/sort_pkg.sv
// Shared definitions for the sort-chain frame sequencer: FSM state encoding
// and the counter-width helpers that are sized from the chain length N.
package sort_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DROP   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_UNLOAD = 3'd5
  } state_e;

  // Frame counter must represent 0..N; the flush counter must represent 0..2N.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int flush_w(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/sort_seq_ctrl_if.sv
// Stream, chain-drive and status signals of the sort sequencer.
// master = sequencer side, slave = surrounding system.
interface sort_seq_ctrl_if #(parameter int HBIT = 8);
  import sort_pkg::*;

  logic [HBIT-1:0] s_data;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;
  logic [HBIT-1:0] m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready;
  logic            arr_hold;
  logic            arr_is_input;
  logic [HBIT-1:0] arr_din;
  logic [HBIT-1:0] arr_dout;
  logic            busy;
  logic            err_overflow;

  modport master (
    input  s_data, s_valid, s_last, m_ready, arr_dout,
    output s_ready, m_data, m_valid, m_last, arr_hold, arr_is_input, arr_din,
           busy, err_overflow
  );

  modport slave (
    output s_data, s_valid, s_last, m_ready, arr_dout,
    input  s_ready, m_data, m_valid, m_last, arr_hold, arr_is_input, arr_din,
           busy, err_overflow
  );

endinterface

// File: rtl/sort_out_fifo.sv
// Synchronous FIFO holding one sorted frame (data plus last tag) with a
// registered occupancy count; push and pop may occur in the same cycle.
module sort_out_fifo
  import sort_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic [cnt_w(DEPTH)-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign do_push_s = push && (count_r != CW'(DEPTH));
  assign do_pop_s  = pop && (count_r != '0);

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

endmodule

// File: rtl/sort_seq_ctrl.sv
// Frame sequencer for a compare-and-swap sort chain: loads up to N words,
// flushes the chain, then unloads the sorted frame (maximum first) into a FIFO.
module sort_seq_ctrl
  import sort_pkg::*;
#(
  parameter int HBIT = 8,
  parameter int N    = 8
) (
  input logic           clk,
  input logic           rst,
  sort_seq_ctrl_if.master bus
);

  localparam int CNT_W   = cnt_w(N);
  localparam int FLUSH_W = flush_w(N);

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [FLUSH_W-1:0]  idx_r, idx_s;
  logic                accept_s;
  logic                ovf_s;
  logic                push_s;
  logic                push_last_s;
  logic [CNT_W-1:0]    fifo_cnt_s;
  logic [HBIT:0]       fifo_rd_s;

  logic                s_ready_r;
  logic                err_r;
  logic                hold_r;
  logic                is_input_r;
  logic [HBIT-1:0]     din_r;
  logic                busy_r;

  assign accept_s = bus.s_valid && s_ready_r;

  // Next-state, counters and FIFO push; idx_r serves as flush and unload index.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    ovf_s       = 1'b0;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    case (state_r)
      ST_CLEAR: state_s = ST_LOAD;
      ST_LOAD: begin
        if (accept_s) begin
          cnt_s = cnt_r + CNT_W'(1);
          if (bus.s_last) begin
            state_s = ST_FLUSH;
            idx_s   = '0;
          end else if (cnt_r == CNT_W'(N - 1)) begin
            state_s = ST_DROP;
            ovf_s   = 1'b1;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_DROP: begin
        if (accept_s && bus.s_last) begin
          state_s = ST_FLUSH;
          idx_s   = '0;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_FLUSH: begin
        if (idx_r == FLUSH_W'(2 * N - 1)) begin
          idx_s = '0;
          // Skip WAIT entirely when the previous frame is already drained.
          if (fifo_cnt_s == '0) begin
            state_s = ST_UNLOAD;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          idx_s = idx_r + FLUSH_W'(1);
        end
      end
      ST_WAIT: begin
        if (fifo_cnt_s == '0) begin
          state_s = ST_UNLOAD;
          idx_s   = '0;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_UNLOAD: begin
        push_s = 1'b1;
        if (idx_r + FLUSH_W'(1) == FLUSH_W'(cnt_r)) begin
          push_last_s = 1'b1;
          state_s     = ST_CLEAR;
          cnt_s       = '0;
          idx_s       = '0;
        end else begin
          idx_s = idx_r + FLUSH_W'(1);
        end
      end
      default: begin
        state_s = ST_CLEAR;
        cnt_s   = '0;
        idx_s   = '0;
      end
    endcase
  end

  // State, counters and registered chain/stream outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_CLEAR;
      cnt_r      <= '0;
      idx_r      <= '0;
      s_ready_r  <= 1'b0;
      err_r      <= 1'b0;
      hold_r     <= 1'b1;
      is_input_r <= 1'b1;
      din_r      <= '0;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      s_ready_r  <= (state_s == ST_LOAD) || (state_s == ST_DROP);
      err_r      <= ovf_s;
      hold_r     <= (state_s == ST_CLEAR);
      is_input_r <= (state_s != ST_UNLOAD);
      din_r      <= ((state_r == ST_LOAD) && bus.s_valid) ? bus.s_data : '0;
      busy_r     <= !((state_s == ST_LOAD) && (cnt_s == '0));
    end
  end

  sort_out_fifo #(
    .W     (HBIT + 1),
    .DEPTH (N)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({push_last_s, bus.arr_dout}),
    .pop       (bus.m_valid && bus.m_ready),
    .rd_data   (fifo_rd_s),
    .count     (fifo_cnt_s)
  );

  assign bus.s_ready      = s_ready_r;
  assign bus.err_overflow = err_r;
  assign bus.arr_hold     = hold_r;
  assign bus.arr_is_input = is_input_r;
  assign bus.arr_din      = din_r;
  assign bus.busy         = busy_r;
  assign bus.m_valid      = (fifo_cnt_s != '0);
  assign bus.m_data       = fifo_rd_s[HBIT-1:0];
  assign bus.m_last       = fifo_rd_s[HBIT];

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Scoreboard bench for sort_seq_ctrl (N=4, HBIT=8) with a behavioural model
// of the compare-and-swap cell chain attached to the arr_* pins.
module tb_sort_seq_ctrl;
  localparam int N    = 4;
  localparam int HBIT = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ovf_cnt = 0;
  logic prev_in = 1'b1;
  logic [HBIT:0] exp_q[$];

  sort_seq_ctrl_if #(.HBIT(HBIT)) bus();

  sort_seq_ctrl #(.HBIT(HBIT), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell chain model: each cell keeps the larger value and passes the smaller
  // one on through a register; unload shifts stored values towards cell 0.
  logic [HBIT-1:0] cv [N];
  logic [HBIT-1:0] cp [N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [HBIT-1:0] x;
      x = (i == 0) ? bus.arr_din : cp[i-1];
      if (bus.arr_hold) begin
        cv[i] <= '0;
        cp[i] <= '0;
      end else if (bus.arr_is_input) begin
        cv[i] <= (x > cv[i]) ? x : cv[i];
        cp[i] <= (x > cv[i]) ? cv[i] : x;
      end else begin
        cv[i] <= (i == N - 1) ? '0 : cv[(i + 1) % N];
      end
    end
  end
  assign bus.arr_dout = cv[0];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Output monitor: pops expected words on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got data=%0d last=%0d, expected nothing",
                   bus.m_data, bus.m_last);
        end else begin
          logic [HBIT:0] e;
          e = exp_q.pop_front();
          if ({bus.m_last, bus.m_data} !== e) begin
            n_fail++;
            $display("FAIL output_word: got data=%0d last=%0d, expected data=%0d last=%0d",
                     bus.m_data, bus.m_last, e[HBIT-1:0], e[HBIT]);
          end
        end
      end
      // Unload may only begin with the output FIFO empty.
      if (prev_in && !bus.arr_is_input) begin
        n_tests++;
        if (bus.m_valid) begin
          n_fail++;
          $display("FAIL unload_start_empty: got m_valid=1, expected 0");
        end
      end
      prev_in = bus.arr_is_input;
      if (bus.err_overflow) ovf_cnt++;
    end
  end

  task automatic push_exp(input logic [HBIT-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic send(input logic [HBIT-1:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t_acc;
    int ovf0;
    bit seen;
    rst         = 1'b1;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_err_overflow", bus.err_overflow, 0);
    check("rst_arr_hold", bus.arr_hold, 1);
    check("rst_arr_is_input", bus.arr_is_input, 1);
    check("rst_arr_din", bus.arr_din, 0);
    check("rst_busy", bus.busy, 1);
    rst = 1'b0;
    gap(2);
    check("idle_busy", bus.busy, 0);
    check("idle_s_ready", bus.s_ready, 1);

    // Frame {3,7,1,5}: sorted 7,5,3,1; first m_valid 2N+1 edges after the
    // s_last handshake edge (cycle t+2N+2 with t the handshake cycle).
    ovf0 = ovf_cnt;
    push_exp(8'd7, 1'b0); push_exp(8'd5, 1'b0);
    push_exp(8'd3, 1'b0); push_exp(8'd1, 1'b1);
    send(8'd3, 1'b0);
    check("busy_after_word", bus.busy, 1);
    send(8'd7, 1'b0);
    send(8'd1, 1'b0);
    send(8'd5, 1'b1);
    t_acc = cyc;
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("first_valid_seen", seen, 1);
    check("first_valid_latency", cyc - t_acc, 2 * N + 1);
    wait_idle();

    // Single-word frame.
    push_exp(8'd9, 1'b1);
    send(8'd9, 1'b1);
    wait_idle();

    // Frame {4,4,0,4} with s_valid gaps.
    push_exp(8'd4, 1'b0); push_exp(8'd4, 1'b0);
    push_exp(8'd4, 1'b0); push_exp(8'd0, 1'b1);
    send(8'd4, 1'b0); gap(2);
    send(8'd4, 1'b0); gap(3);
    send(8'd0, 1'b0); gap(1);
    send(8'd4, 1'b1);
    wait_idle();
    check("no_overflow_full_frame", ovf_cnt - ovf0, 0);

    // Overflow: six words, 5 and 6 dropped.
    ovf0 = ovf_cnt;
    push_exp(8'd4, 1'b0); push_exp(8'd3, 1'b0);
    push_exp(8'd2, 1'b0); push_exp(8'd1, 1'b1);
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    check("ovf_pulse_on_4th", bus.err_overflow, 1);
    send(8'd5, 1'b0);
    check("ovf_one_cycle", bus.err_overflow, 0);
    send(8'd6, 1'b1);
    wait_idle();
    check("ovf_pulse_count", ovf_cnt - ovf0, 1);

    // Back-pressure: m_ready low for 50 cycles across three frames.
    push_exp(8'd4, 1'b0); push_exp(8'd3, 1'b0);
    push_exp(8'd2, 1'b0); push_exp(8'd1, 1'b1);
    push_exp(8'd20, 1'b0); push_exp(8'd10, 1'b1);
    push_exp(8'd6, 1'b0); push_exp(8'd5, 1'b0); push_exp(8'd5, 1'b1);
    fork
      begin
        bus.m_ready = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
      end
      begin
        send(8'd3, 1'b0); send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd4, 1'b1);
        send(8'd10, 1'b0); send(8'd20, 1'b1);
        send(8'd5, 1'b0); send(8'd5, 1'b0); send(8'd6, 1'b1);
      end
    join
    wait_idle();

    // Reset during UNLOAD, then frame {2,8}.
    bus.m_ready = 1'b0;
    send(8'd6, 1'b0); send(8'd3, 1'b0); send(8'd9, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!bus.arr_is_input) begin
        seen = 1'b1;
        break;
      end
    end
    check("unload_reached", seen, 1);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_valid", bus.m_valid, 0);
    check("midrst_arr_hold", bus.arr_hold, 1);
    check("midrst_s_ready", bus.s_ready, 0);
    rst = 1'b0;
    bus.m_ready = 1'b1;
    wait_idle();
    push_exp(8'd8, 1'b0); push_exp(8'd2, 1'b1);
    send(8'd2, 1'b0);
    send(8'd8, 1'b1);
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
